// File: rtl/commut_pkg.sv
// Shared definitions for the commutator and its frame reader: frame geometry
// and the frame-reader state encoding (3 bits, IDLE = 0).
package commut_pkg;

  localparam int COMMUT_N_WORDS = 20;
  localparam int COMMUT_AW      = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/commut_frame_rd.sv
// Reads a complete frame back from the frame RAM and streams it out on a
// valid/ready interface, optionally followed by a modular checksum word.
module commut_frame_rd
  import commut_pkg::*;
#(
  parameter int DW       = 16,
  parameter int N_WORDS  = COMMUT_N_WORDS,
  parameter int RD_LAT   = 1,
  parameter int ADD_CSUM = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 full,
  input  logic [DW-1:0]        rdData,
  output logic [COMMUT_AW-1:0] rdAdr,
  output logic                 rdEn,
  output logic [DW-1:0]        txData,
  output logic                 txValid,
  input  logic                 txReady,
  output logic                 txLast,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam logic [COMMUT_AW-1:0] LAST_IDX = COMMUT_AW'(N_WORDS - 1);
  localparam logic [1:0]           LAT_LAST = 2'(RD_LAT - 1);
  localparam bit                   CSUM_EN  = (ADD_CSUM != 0);

  state_t               state, state_n;
  logic                 fullD;
  logic                 start;
  logic                 xfer;
  logic                 lat_hit;
  logic                 last_word;
  logic [COMMUT_AW-1:0] wordCnt;
  logic [1:0]           latCnt;
  logic [DW-1:0]        csum;

  assign start     = full & ~fullD;
  assign xfer      = txValid & txReady;
  assign lat_hit   = (latCnt == LAT_LAST);
  assign last_word = (wordCnt == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    rdEn    = 1'b0;
    rdAdr   = '0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_n = ST_ISSUE;
      end
      ST_ISSUE: begin
        rdEn    = 1'b1;
        rdAdr   = wordCnt;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_hit) state_n = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          if (!last_word)   state_n = ST_ISSUE;
          else if (CSUM_EN) state_n = ST_CSUM;
          else              state_n = ST_DONE;
        end
      end
      ST_CSUM: begin
        if (xfer) state_n = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fullD   <= 1'b0;
      wordCnt <= '0;
      latCnt  <= '0;
      csum    <= '0;
      txData  <= '0;
      txValid <= 1'b0;
      txLast  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      fullD <= full;
      if (start && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            wordCnt <= '0;
            csum    <= '0;
          end
        end
        ST_ISSUE: latCnt <= '0;
        ST_WAIT: begin
          if (lat_hit) begin
            txData  <= rdData;
            txValid <= 1'b1;
            txLast  <= last_word && !CSUM_EN;
            csum    <= csum + rdData;
          end else begin
            latCnt <= latCnt + 2'd1;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            txValid <= 1'b0;
            txLast  <= 1'b0;
            if (!last_word) wordCnt <= wordCnt + COMMUT_AW'(1);
          end
        end
        // First CSUM cycle presents the checksum; later cycles wait for the transfer.
        ST_CSUM: begin
          if (!txValid) begin
            txData  <= csum;
            txValid <= 1'b1;
            txLast  <= 1'b1;
          end else if (txReady) begin
            txValid <= 1'b0;
            txLast  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
